ahb_print_master: RTL
=====================

// Module: ahb_print_master
// PURPOSE
//  AHB-Lite single-transfer initiator for the simulation print/counter window at PRINT_ADDR.
//  - Drains a byte FIFO, issuing one word write per character (char on hwdata[7:0]), which the
//    bus-side print monitor emits via $write.
//  - On request, issues a word read of the same address to fetch the virtual cycle counter.
//  - Sits in the SoC testbench as an alternate bus master feeding the same AHB matrix port.
// PARAMETERS
//  PRINT_ADDR   32'h2001FFF0  target address for print writes and counter reads
//  FIFO_DEPTH   8             character FIFO entries (power of two, >=2)
//  FIFO_AW      3             log2(FIFO_DEPTH)
// PORTS
//  sysclk      in   1   bus clock
//  sysrst      in   1   synchronous reset, active-high
//  char_valid  in   1   character offered
//  char_data   in   8   character byte
//  char_ready  out  1   FIFO can accept (= !full)
//  cnt_req     in   1   one-cycle pulse: request counter read
//  cnt_done    out  1   one-cycle pulse: counter read finished
//  cnt_value   out  32  last counter value read (held until next cnt_done)
//  cnt_err     out  1   valid with cnt_done: read ended in ERROR response
//  err_pulse   out  1   one-cycle pulse on any ERROR-terminated transfer
//  htrans      out  2   IDLE 2'b00 / NONSEQ 2'b10 only
//  haddr       out  32  PRINT_ADDR during NONSEQ, else 0
//  hwrite      out  1   1 = print write, 0 = counter read
//  hsize       out  3   constant 3'b010 (word)
//  hburst      out  3   constant 3'b000 (SINGLE)
//  hprot       out  4   constant 4'b0011
//  hwdata      out  32  {24'b0, char} during write data phase, else 0
//  hready      in   1   transfer ready
//  hresp       in   2   2'b00 OKAY, 2'b01 ERROR
//  hrdata      in   32  read data
// BEHAVIOUR
//  - Reset (sysrst high at posedge): FIFO emptied, FSM=IDLE, read-pending cleared; htrans=IDLE,
//    haddr=0, hwrite=0, hwdata=0, cnt_done=0, cnt_value=0, cnt_err=0, err_pulse=0. Reset
//    mid-transfer abandons it; htrans is IDLE the cycle after reset asserts.
//  - FIFO: push on char_valid&&char_ready; pop when a write address phase is accepted. Full ->
//    char_ready=0, input ignored. Pointers wrap modulo FIFO_DEPTH; separate count register.
//  - cnt_req sets read-pending; further cnt_req while pending or in flight are merged (no 2nd read).
//  - FSM IDLE -> ADDR (at posedge when pending || !empty; read has priority over write) -> DATA -> IDLE.
//    ADDR: htrans=NONSEQ, haddr=PRINT_ADDR, hwrite per selected op; held stable until hready=1.
//    DATA: htrans=IDLE; hwdata={24'b0,char} for writes; completes on hready=1. No back-to-back
//    pipelining: at least one IDLE-FSM cycle between transfers.
//  - Latency: char pushed in cycle N on idle bus -> NONSEQ in cycle N+2, data phase N+3 (zero wait).
//  - Read completion (hready=1, hresp=OKAY): cnt_value<=hrdata, cnt_done=1, cnt_err=0 next cycle.
//  - ERROR: first cycle hresp=ERROR,hready=0 -> master keeps htrans=IDLE; on second cycle (hready=1)
//    transfer ends, err_pulse=1 one cycle; read -> cnt_done=1,cnt_err=1,cnt_value unchanged;
//    write -> char dropped (already popped), no retry.
//  - Push and pop in same cycle: count unchanged, both take effect; push allowed when full only if
//    not full at cycle start (char_ready is registered-count based, no bypass).
// STRUCTURE
//  - Shared package ahb_tb_pkg: HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR, HSIZE_WORD, HBURST_SINGLE,
//    PRINT_ADDR default, FSM state typedef {S_IDLE,S_ADDR,S_DATA}.
//  - One sub-module: print_char_fifo (sync FIFO, FIFO_DEPTH x 8, push/pop/full/empty/count).
// TESTING
//  - Push "Hi\n" (8'h48,8'h69,8'h0A), hready=1 -> three NONSEQ writes to 2001FFF0, hwdata 0x48,0x69,0x0A in order.
//  - Push 9 chars back-to-back, hready=0 -> char_ready low after 8th; 9th held until first pop.
//  - cnt_req with hrdata=32'h0000_1234 -> single read NONSEQ, cnt_done pulse, cnt_value=0x1234.
//  - cnt_req and char push same cycle -> read issued first, then write.
//  - hready low 3 cycles in address phase -> htrans/haddr/hwrite stable all 4 cycles.
//  - Write with 2-cycle ERROR -> err_pulse=1 once, next char proceeds; sysrst mid-DATA -> htrans IDLE, FIFO empty.

Source files
------------

// File: rtl/ahb_tb_pkg.sv
// ahb_tb_pkg: shared AHB-Lite encodings and print-master FSM states
//   HTRANS/HRESP/HSIZE/HBURST/HPROT codes, default print window address, state_t
package ahb_tb_pkg;
    localparam logic [1:0]  HTRANS_IDLE        = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ      = 2'b10;
    localparam logic [1:0]  HRESP_OKAY         = 2'b00;
    localparam logic [1:0]  HRESP_ERROR        = 2'b01;
    localparam logic [2:0]  HSIZE_WORD         = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE      = 3'b000;
    localparam logic [3:0]  HPROT_DEFAULT      = 4'b0011;
    localparam logic [31:0] PRINT_ADDR_DEFAULT = 32'h2001_FFF0;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
endpackage

// File: rtl/print_char_fifo.sv
// print_char_fifo: synchronous DEPTH x 8 character FIFO
//   sysclk/sysrst : clock, sync active-high reset (empties FIFO)
//   push/wdata    : write request (ignored when full)
//   pop/rdata     : read request (ignored when empty), rdata shows head entry
//   full/empty    : status derived from the occupancy count register
module print_char_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       sysclk,
    input  logic       sysrst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ahb_print_master.sv
// ahb_print_master: AHB-Lite single-transfer initiator for the print/counter window
//   sysclk/sysrst           : clock, sync active-high reset
//   char_valid/data/ready   : character input into the FIFO (ready = !full)
//   cnt_req                 : pulse requesting a counter read
//   cnt_done/value/err      : counter read completion, last good value, error flag
//   err_pulse               : pulse on any ERROR-terminated transfer
//   htrans..hwdata          : AHB-Lite master outputs (IDLE/NONSEQ single word transfers)
//   hready/hresp/hrdata     : AHB-Lite slave responses
module ahb_print_master
    import ahb_tb_pkg::*;
#(
    parameter logic [31:0] PRINT_ADDR = PRINT_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = 3
) (
    input  logic        sysclk,
    input  logic        sysrst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        cnt_req,
    output logic        cnt_done,
    output logic [31:0] cnt_value,
    output logic        cnt_err,
    output logic        err_pulse,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);
    state_t     state, state_nxt;
    logic       op_wr, rd_pend, rd_busy;
    logic       fifo_empty, fifo_full, start, pop, done, err;
    logic [7:0] fifo_rdata, wchar;

    assign hsize      = HSIZE_WORD;
    assign hburst     = HBURST_SINGLE;
    assign hprot      = HPROT_DEFAULT;
    assign char_ready = !fifo_full;
    assign start      = state == S_IDLE && (rd_pend || !fifo_empty);
    assign pop        = state == S_ADDR && hready && op_wr;
    assign done       = state == S_DATA && hready;
    assign err        = hresp == HRESP_ERROR;
    // A read already on the bus absorbs any further requests
    assign rd_busy    = state != S_IDLE && !op_wr;

    print_char_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .push   (char_valid),
        .wdata  (char_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        htrans    = HTRANS_IDLE;
        haddr     = '0;
        hwrite    = 1'b0;
        hwdata    = '0;
        case (state)
            S_IDLE: if (start) state_nxt = S_ADDR;
            S_ADDR: begin
                htrans = HTRANS_NONSEQ;
                haddr  = PRINT_ADDR;
                hwrite = op_wr;
                if (hready) state_nxt = S_DATA;
            end
            S_DATA: begin
                hwdata = op_wr ? {24'b0, wchar} : '0;
                if (hready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state     <= S_IDLE;
            op_wr     <= 1'b0;
            rd_pend   <= 1'b0;
            wchar     <= '0;
            cnt_done  <= 1'b0;
            cnt_err   <= 1'b0;
            cnt_value <= '0;
            err_pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            // Pending read wins arbitration over queued characters
            if (start) op_wr <= !rd_pend;
            rd_pend <= (start && rd_pend) ? 1'b0 : (rd_pend || (cnt_req && !rd_busy));
            // The char leaves the FIFO at address accept, so keep it for the data phase
            if (pop) wchar <= fifo_rdata;
            cnt_done  <= done && !op_wr;
            cnt_err   <= done && !op_wr && err;
            err_pulse <= done && err;
            if (done && !op_wr && !err) cnt_value <= hrdata;
        end
    end
endmodule
